cpu_axi_bridge: RTL and testbench
=================================

// Module: cpu_axi_bridge
// PURPOSE
//  Converts the core's two SRAM-like ports (inst: read-only, data: read/write; req/addr_ok/data_ok)
//  into one AXI3 master. Sits between the CPU top and the AXI interconnect/RAM.
//  Single-beat transfers only. At most one outstanding transaction per SRAM master.
// PARAMETERS
//  ID_INST  4'd0  arid used for instruction reads; rid==ID_INST routes to inst port
//  ID_DATA  4'd1  arid/awid/wid used for data accesses; any other rid routes to data port
// PORTS
//  clk      in   1  clock, all state updates on posedge
//  reset    in   1  synchronous, active-high
//  inst_sram_{req,wr,size,wstrb,addr,wdata}  in   1/1/2/4/32/32  inst request; wr/wstrb/wdata ignored
//  inst_sram_{addr_ok,data_ok}               out  1/1  request accepted / read data valid
//  inst_sram_rdata                           out  32   = rdata
//  data_sram_{req,wr,size,wstrb,addr,wdata}  in   1/1/2/4/32/32  data request
//  data_sram_{addr_ok,data_ok}               out  1/1  request accepted / read data or write done
//  data_sram_rdata                           out  32   = rdata
//  arid,araddr,arlen,arsize,arburst,arlock,arcache,arprot  out  4/32/8/3/2/2/4/3  AR payload
//  arvalid out 1 / arready in 1               AR handshake
//  rid,rdata,rresp,rlast,rvalid               in   4/32/2/1/1  R channel; rready out 1
//  awid,awaddr,awlen,awsize,awburst,awlock,awcache,awprot  out  same widths as AR
//  awvalid out 1 / awready in 1               AW handshake
//  wid,wdata,wstrb,wlast,wvalid               out  4/32/4/1/1; wready in 1
//  bid,bresp,bvalid                           in   4/2/1; bready out 1
// BEHAVIOUR
//  Constants: ar/awlen=0, ar/awburst=2'b01, ar/awlock=0, ar/awcache=0, ar/awprot=0, wlast=1,
//   awid=wid=ID_DATA; ar/awsize={1'b0,size} latched at accept.
//  Reset: arvalid=awvalid=wvalid=bready=rready=0; addr_ok=data_ok=0; flags inst_busy, data_busy=0;
//   AR FSM and W FSM -> IDLE. Reset mid-transaction abandons it; no replay.
//  rready: 1 every cycle after reset (masters always accept data_ok).
//  AR FSM: AR_IDLE -> AR_SEND on read accept; AR_SEND holds arvalid=1, payload stable until arready -> AR_IDLE.
//  Read accept (AR_IDLE only, combinational addr_ok, at most one per cycle):
//   data read eligible = data_sram_req & ~data_sram_wr & ~data_busy & W FSM==W_IDLE;
//   inst read eligible = inst_sram_req & ~inst_busy; data has priority; loser gets addr_ok=0.
//   Accept latches addr/size/id and sets the master's busy flag.
//  R handshake (rvalid&rready): rid==ID_INST -> inst_sram_data_ok=1, clear inst_busy;
//   else data_sram_data_ok=1, clear data_busy. rdata passed combinationally (0-cycle added latency).
//  W FSM: W_IDLE -> W_SEND on write accept; W_SEND asserts awvalid and wvalid, each drops
//   independently on its own handshake (either order, or same cycle); when both done -> W_RESP;
//   W_RESP bready=1, on bvalid -> data_sram_data_ok=1, clear data_busy, -> W_IDLE.
//  Write accept: data_sram_req & data_sram_wr & ~data_busy & W FSM==W_IDLE (addr_ok combinational),
//   latches addr/size/wstrb/wdata, sets data_busy. Independent of AR FSM state.
//  Ordering: data_busy covers reads and writes, so a data read never overtakes a write (RAW safe)
//   and data read data_ok and write data_ok never coincide.
//  Inst and data read responses may arrive in either order; routing is by rid only.
//  Minimum read: accept cycle N, arvalid N+1; with arready=1 and rvalid at N+2, data_ok at N+2.
//  rresp/bresp ignored.
// TESTING
//  1 inst read 0x1c000000, arready=1, rvalid 1 cycle later rdata=0x02800c0c
//    -> addr_ok in cycle 0; arid=0, arsize=2; inst data_ok with rdata 0x02800c0c.
//  2 inst and data read requested in the same cycle -> data addr_ok=1, inst addr_ok=0;
//    inst accepted the cycle AR_SEND returns to AR_IDLE.
//  3 data write addr 0x100, wdata 0xdeadbeef, wstrb 4'b0011, size=1, wready 3 cycles before awready
//    -> awsize=1, wstrb=0011; W_RESP only after both handshakes; data_ok on bvalid.
//  4 data read 0x100 requested while write in W_SEND/W_RESP -> data addr_ok=0 until write data_ok;
//    read accepted the next eligible cycle.
//  5 responses out of order: rid=1 returned before rid=0 -> data_ok routed to the data port,
//    inst port unaffected; busy flags cleared independently.
//  6 reset asserted while in AR_SEND and W_RESP -> next cycle all valids=0, FSMs IDLE, busy flags=0.

Source files
------------

// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge: merges the inst (read-only) and data (read/write) SRAM-like ports into one single-beat AXI3 master
module cpu_axi_bridge #(
  parameter logic [3:0] ID_INST = 4'd0,
  parameter logic [3:0] ID_DATA = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);
  typedef enum logic {AR_IDLE, AR_SEND} ar_state_t;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;
  ar_state_t ar_state, ar_next;
  w_state_t w_state, w_next;
  logic inst_busy, data_busy, aw_pend, w_pend, rready_q;
  logic data_rd, inst_rd, data_wr, r_hs, r_inst, r_data, b_done, aw_done, w_done;
  logic unused_ins;
  assign unused_ins = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rresp, rlast, bid, bresp};
  assign data_rd = ~reset & data_sram_req & ~data_sram_wr & ~data_busy & (w_state == W_IDLE) & (ar_state == AR_IDLE);
  assign inst_rd = ~reset & inst_sram_req & ~inst_busy & (ar_state == AR_IDLE) & ~data_rd;
  assign data_wr = ~reset & data_sram_req & data_sram_wr & ~data_busy & (w_state == W_IDLE);
  assign r_hs = rvalid & rready;
  assign r_inst = r_hs & (rid == ID_INST);
  assign r_data = r_hs & (rid != ID_INST);
  assign b_done = bvalid & bready;
  assign aw_done = ~aw_pend | awready;
  assign w_done = ~w_pend | wready;
  assign inst_sram_addr_ok = inst_rd;
  assign data_sram_addr_ok = data_rd | data_wr;
  assign inst_sram_data_ok = r_inst;
  assign data_sram_data_ok = r_data | b_done;
  assign inst_sram_rdata = rdata;
  assign data_sram_rdata = rdata;
  assign rready = rready_q;
  assign arvalid = ar_state == AR_SEND;
  assign awvalid = (w_state == W_SEND) & aw_pend;
  assign wvalid = (w_state == W_SEND) & w_pend;
  assign bready = ~reset & (w_state == W_RESP);
  assign {arlen, awlen} = '0;
  assign {arburst, awburst} = {2'b01, 2'b01};
  assign {arlock, awlock, arcache, awcache, arprot, awprot} = '0;
  assign awid = ID_DATA;
  assign wid = ID_DATA;
  assign wlast = 1'b1;
  always_comb begin
    ar_next = ar_state;
    w_next = w_state;
    ar_next = (ar_state == AR_IDLE) ? ((data_rd | inst_rd) ? AR_SEND : AR_IDLE) : (arready ? AR_IDLE : AR_SEND);
    w_next = (w_state == W_IDLE) ? (data_wr ? W_SEND : W_IDLE) :
             (w_state == W_SEND) ? ((aw_done & w_done) ? W_RESP : W_SEND) :
             (w_state == W_RESP) ? (bvalid ? W_IDLE : W_RESP) : W_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ar_state <= AR_IDLE;
      w_state <= W_IDLE;
      inst_busy <= 1'b0;
      data_busy <= 1'b0;
      aw_pend <= 1'b0;
      w_pend <= 1'b0;
      rready_q <= 1'b0;
    end else begin
      ar_state <= ar_next;
      w_state <= w_next;
      rready_q <= 1'b1;
      inst_busy <= inst_rd | (inst_busy & ~r_inst);
      data_busy <= data_rd | data_wr | (data_busy & ~data_sram_data_ok);
      aw_pend <= data_wr | (aw_pend & ~(awvalid & awready));
      w_pend <= data_wr | (w_pend & ~(wvalid & wready));
    end
  end
  always_ff @(posedge clk) begin
    if (data_rd | inst_rd) begin
      araddr <= data_rd ? data_sram_addr : inst_sram_addr;
      arsize <= {1'b0, data_rd ? data_sram_size : inst_sram_size};
      arid <= data_rd ? ID_DATA : ID_INST;
    end
    if (data_wr) begin
      awaddr <= data_sram_addr;
      awsize <= {1'b0, data_sram_size};
      wdata <= data_sram_wdata;
      wstrb <= data_sram_wstrb;
    end
  end
endmodule

// File: tb/tb_cpu_axi_bridge.sv
// tb_cpu_axi_bridge: directed vector and sequence checks of cpu_axi_bridge
module tb_cpu_axi_bridge;
  logic clk = 1'b0, reset;
  logic inst_sram_req, inst_sram_wr, inst_sram_addr_ok, inst_sram_data_ok;
  logic [1:0] inst_sram_size;
  logic [3:0] inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
  logic data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
  logic [1:0] data_sram_size;
  logic [3:0] data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic [3:0] arid, awid, wid, rid, bid, arcache, awcache, wstrb;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize, arprot, awprot;
  logic [1:0] arburst, awburst, arlock, awlock, rresp, bresp;
  logic arvalid, arready, rlast, rvalid, rready, awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  int compared = 0, mismatched = 0;
  typedef struct {
    logic inst;
    logic [31:0] addr;
    logic [1:0] size;
    logic [31:0] rdata;
    logic [3:0] exp_arid;
    logic [2:0] exp_arsize;
  } vec_t;
  vec_t vecs[4];
  cpu_axi_bridge dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic step;
    @(negedge clk);
  endtask
  initial begin
    vecs[0] = '{1'b1, 32'h1c00_0000, 2'd2, 32'h0280_0c0c, 4'd0, 3'd2};
    vecs[1] = '{1'b0, 32'h0000_0100, 2'd1, 32'h1234_5678, 4'd1, 3'd1};
    vecs[2] = '{1'b0, 32'h8000_0004, 2'd0, 32'ha5a5_a5a5, 4'd1, 3'd0};
    vecs[3] = '{1'b1, 32'h1c00_0004, 2'd2, 32'h0000_0000, 4'd0, 3'd2};
    reset = 1'b1;
    {inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_addr, inst_sram_wdata} = '0;
    {data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata} = '0;
    {arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid} = '0;
    repeat (3) step();
    #1;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_rready", rready, 0);
    reset = 1'b0;
    step();
    #1;
    chk("rready_after_rst", rready, 1);
    for (int i = 0; i < 4; i++) begin
      inst_sram_req = vecs[i].inst;
      data_sram_req = ~vecs[i].inst;
      data_sram_wr = 1'b0;
      inst_sram_addr = vecs[i].addr;
      data_sram_addr = vecs[i].addr;
      inst_sram_size = vecs[i].size;
      data_sram_size = vecs[i].size;
      #1;
      chk("v_inst_addr_ok", inst_sram_addr_ok, vecs[i].inst);
      chk("v_data_addr_ok", data_sram_addr_ok, !vecs[i].inst);
      chk("v_arvalid_accept", arvalid, 0);
      step();
      inst_sram_req = 1'b0;
      data_sram_req = 1'b0;
      #1;
      chk("v_arvalid", arvalid, 1);
      chk("v_araddr", araddr, vecs[i].addr);
      chk("v_arsize", arsize, vecs[i].exp_arsize);
      chk("v_arid", arid, vecs[i].exp_arid);
      chk("v_arlen_burst", {arlen, arburst}, {8'd0, 2'b01});
      arready = 1'b1;
      step();
      arready = 1'b0;
      rvalid = 1'b1;
      rid = vecs[i].exp_arid;
      rdata = vecs[i].rdata;
      #1;
      chk("v_arvalid_done", arvalid, 0);
      chk("v_inst_data_ok", inst_sram_data_ok, vecs[i].inst);
      chk("v_data_data_ok", data_sram_data_ok, !vecs[i].inst);
      chk("v_rdata", vecs[i].inst ? inst_sram_rdata : data_sram_rdata, vecs[i].rdata);
      step();
      rvalid = 1'b0;
      #1;
      chk("v_data_ok_clear", {inst_sram_data_ok, data_sram_data_ok}, 0);
    end
    inst_sram_req = 1'b1;
    inst_sram_addr = 32'h1c00_0010;
    inst_sram_size = 2'd2;
    data_sram_req = 1'b1;
    data_sram_wr = 1'b0;
    data_sram_addr = 32'h0000_0200;
    data_sram_size = 2'd2;
    #1;
    chk("pri_data_addr_ok", data_sram_addr_ok, 1);
    chk("pri_inst_addr_ok", inst_sram_addr_ok, 0);
    step();
    data_sram_req = 1'b0;
    #1;
    chk("pri_arid_data", arid, 4'd1);
    chk("pri_araddr_data", araddr, 32'h0000_0200);
    chk("pri_inst_wait", inst_sram_addr_ok, 0);
    step();
    #1;
    chk("pri_ar_hold", {arvalid, araddr}, {1'b1, 32'h0000_0200});
    chk("pri_inst_wait2", inst_sram_addr_ok, 0);
    arready = 1'b1;
    step();
    arready = 1'b0;
    #1;
    chk("pri_inst_accept", inst_sram_addr_ok, 1);
    step();
    #1;
    chk("pri_arid_inst", {arvalid, arid, araddr}, {1'b1, 4'd0, 32'h1c00_0010});
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid = 1'b1;
    rid = 4'd1;
    rdata = 32'h1111_2222;
    #1;
    chk("ooo_data_ok", {data_sram_data_ok, inst_sram_data_ok}, 2'b10);
    chk("ooo_data_rdata", data_sram_rdata, 32'h1111_2222);
    chk("ooo_inst_busy", inst_sram_addr_ok, 0);
    step();
    inst_sram_req = 1'b0;
    rid = 4'd0;
    rdata = 32'h3333_4444;
    data_sram_req = 1'b1;
    data_sram_addr = 32'h0000_0300;
    #1;
    chk("ooo_inst_ok", {data_sram_data_ok, inst_sram_data_ok}, 2'b01);
    chk("ooo_inst_rdata", inst_sram_rdata, 32'h3333_4444);
    chk("ooo_data_free", data_sram_addr_ok, 1);
    step();
    rvalid = 1'b0;
    data_sram_req = 1'b0;
    #1;
    chk("ooo_ar3", {arvalid, arid, araddr}, {1'b1, 4'd1, 32'h0000_0300});
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid = 1'b1;
    rid = 4'd1;
    rdata = 32'h5555_6666;
    #1;
    chk("ooo_data_ok3", {data_sram_data_ok, inst_sram_data_ok}, 2'b10);
    step();
    rvalid = 1'b0;
    data_sram_req = 1'b1;
    data_sram_wr = 1'b1;
    data_sram_size = 2'd1;
    data_sram_addr = 32'h0000_0100;
    data_sram_wdata = 32'hdead_beef;
    data_sram_wstrb = 4'b0011;
    #1;
    chk("wr_addr_ok", data_sram_addr_ok, 1);
    chk("wr_awvalid_accept", awvalid, 0);
    step();
    data_sram_req = 1'b0;
    data_sram_wr = 1'b0;
    #1;
    chk("wr_valids", {awvalid, wvalid, bready}, 3'b110);
    chk("wr_awaddr", awaddr, 32'h0000_0100);
    chk("wr_awsize", awsize, 3'd1);
    chk("wr_wdata", wdata, 32'hdead_beef);
    chk("wr_wstrb", wstrb, 4'b0011);
    chk("wr_ids", {awid, wid, wlast}, {4'd1, 4'd1, 1'b1});
    wready = 1'b1;
    step();
    wready = 1'b0;
    data_sram_req = 1'b1;
    data_sram_addr = 32'h0000_0100;
    data_sram_size = 2'd2;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("wr_w_only", {awvalid, wvalid, bready}, 3'b100);
      chk("raw_blocked_send", data_sram_addr_ok, 0);
      if (c == 2) awready = 1'b1;
      step();
    end
    awready = 1'b0;
    #1;
    chk("wr_resp", {awvalid, wvalid, bready}, 3'b001);
    chk("raw_blocked_resp", data_sram_addr_ok, 0);
    chk("wr_no_early_ok", data_sram_data_ok, 0);
    step();
    bvalid = 1'b1;
    #1;
    chk("wr_data_ok", data_sram_data_ok, 1);
    chk("raw_blocked_b", data_sram_addr_ok, 0);
    step();
    bvalid = 1'b0;
    #1;
    chk("wr_done", {data_sram_data_ok, bready}, 2'b00);
    chk("raw_accept", data_sram_addr_ok, 1);
    step();
    data_sram_req = 1'b0;
    #1;
    chk("raw_ar", {arvalid, arid, araddr, arsize}, {1'b1, 4'd1, 32'h0000_0100, 3'd2});
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid = 1'b1;
    rid = 4'd1;
    rdata = 32'h0000_beef;
    #1;
    chk("raw_data_ok", {data_sram_data_ok, data_sram_rdata}, {1'b1, 32'h0000_beef});
    step();
    rvalid = 1'b0;
    inst_sram_req = 1'b1;
    inst_sram_addr = 32'h1c00_0020;
    data_sram_req = 1'b1;
    data_sram_wr = 1'b1;
    data_sram_addr = 32'h0000_0400;
    #1;
    chk("rst6_both_accept", {inst_sram_addr_ok, data_sram_addr_ok}, 2'b11);
    step();
    inst_sram_req = 1'b0;
    data_sram_req = 1'b0;
    data_sram_wr = 1'b0;
    #1;
    chk("rst6_valids", {arvalid, awvalid, wvalid}, 3'b111);
    awready = 1'b1;
    wready = 1'b1;
    step();
    awready = 1'b0;
    wready = 1'b0;
    #1;
    chk("rst6_pre", {arvalid, awvalid, wvalid, bready}, 4'b1001);
    reset = 1'b1;
    step();
    reset = 1'b0;
    inst_sram_req = 1'b1;
    data_sram_req = 1'b1;
    data_sram_wr = 1'b1;
    #1;
    chk("rst6_valids_low", {arvalid, awvalid, wvalid, bready}, 4'b0000);
    chk("rst6_busy_clear", {inst_sram_addr_ok, data_sram_addr_ok}, 2'b11);
    step();
    inst_sram_req = 1'b0;
    data_sram_req = 1'b0;
    data_sram_wr = 1'b0;
    #1;
    chk("rst6_rready", rready, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
